// File: rtl/dc_sweep_pkg.sv
// rtl/dc_sweep_pkg.sv - shared state encoding and saturating arithmetic for the bias sweep
package dc_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CONV,
        EMIT,
        DONE
    } state_t;

    function automatic int sat_add_val(input int code, input int step, input int max_code);
        int sum;
        sum = code + step;
        if (sum < 0) return 0;
        if (sum > max_code) return max_code;
        return sum;
    endfunction

    function automatic logic sat_add_clip(input int code, input int step, input int max_code);
        int sum;
        sum = code + step;
        return (sum < 0) || (sum > max_code);
    endfunction

    // Only the most-negative sample has no positive twin; it pins to the top of range.
    function automatic int sat_neg(input int v, input int min_v, input int max_v);
        return (v == min_v) ? max_v : -v;
    endfunction

endpackage

// File: rtl/sweep_axis_counter.sv
// rtl/sweep_axis_counter.sv - one sweep axis: point index, clamped DAC code and end-of-axis flag
module sweep_axis_counter
    import dc_sweep_pkg::*;
#(
    parameter int DAC_W = 12,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             adv,
    input  logic             wrap,
    input  logic [DAC_W-1:0] cfg_start,
    input  logic [DAC_W:0]   cfg_step,
    input  logic [IDX_W-1:0] cfg_npts,
    output logic [DAC_W-1:0] code,
    output logic [IDX_W-1:0] idx,
    output logic             last,
    output logic             step_clip
);

    localparam int CODE_MAX = (1 << DAC_W) - 1;

    logic [DAC_W-1:0] start_q;
    logic [DAC_W:0]   step_q;
    logic [IDX_W-1:0] last_idx_q;
    int               code_i;
    int               step_i;

    assign code_i    = int'(code);
    assign step_i    = int'($signed(step_q));
    assign step_clip = sat_add_clip(code_i, step_i, CODE_MAX);
    assign last      = (idx == last_idx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= '0;
            step_q     <= '0;
            last_idx_q <= '0;
            code       <= '0;
            idx        <= '0;
        end else if (init) begin
            start_q    <= cfg_start;
            step_q     <= cfg_step;
            // A zero point count still produces one point.
            last_idx_q <= (cfg_npts == '0) ? '0 : cfg_npts - 1'b1;
            code       <= cfg_start;
            idx        <= '0;
        end else if (wrap) begin
            code <= start_q;
            idx  <= '0;
        end else if (adv) begin
            code <= DAC_W'(sat_add_val(code_i, step_i, CODE_MAX));
            idx  <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/dc_bias_sweep_sequencer.sv
// rtl/dc_bias_sweep_sequencer.sv - gate/drain 2-D bias sweep with settle, ADC capture and result stream
module dc_bias_sweep_sequencer
    import dc_sweep_pkg::*;
#(
    parameter int DAC_W  = 12,
    parameter int ADC_W  = 16,
    parameter int IDX_W  = 8,
    parameter int SET_W  = 16,
    parameter int NEG_ID = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DAC_W-1:0] vgs_start,
    input  logic [DAC_W:0]   vgs_step,
    input  logic [IDX_W-1:0] vgs_npts,
    input  logic [DAC_W-1:0] vds_start,
    input  logic [DAC_W:0]   vds_step,
    input  logic [IDX_W-1:0] vds_npts,
    input  logic [SET_W-1:0] settle_cycles,
    output logic [DAC_W-1:0] vgs_code,
    output logic [DAC_W-1:0] vds_code,
    output logic             dac_load,
    output logic             adc_req,
    input  logic             adc_ack,
    input  logic [ADC_W-1:0] adc_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ADC_W-1:0] res_id,
    output logic [IDX_W-1:0] res_gi,
    output logic [IDX_W-1:0] res_di,
    output logic             res_last,
    output logic             busy,
    output logic             done,
    output logic             clip
);

    localparam int ADC_MAX = (1 << (ADC_W - 1)) - 1;
    localparam int ADC_MIN = -(1 << (ADC_W - 1));

    state_t           state, state_n;
    logic [SET_W-1:0] settle_q, settle_cnt;
    logic [ADC_W-1:0] sample_q, sample_n;
    logic             ax_init, vgs_adv, vds_adv, vds_wrap;
    logic             vgs_last, vds_last, vgs_clip, vds_clip;

    sweep_axis_counter #(.DAC_W(DAC_W), .IDX_W(IDX_W)) u_vgs_axis (
        .clk(clk), .rst_n(rst_n), .init(ax_init), .adv(vgs_adv), .wrap(1'b0),
        .cfg_start(vgs_start), .cfg_step(vgs_step), .cfg_npts(vgs_npts),
        .code(vgs_code), .idx(res_gi), .last(vgs_last), .step_clip(vgs_clip)
    );

    sweep_axis_counter #(.DAC_W(DAC_W), .IDX_W(IDX_W)) u_vds_axis (
        .clk(clk), .rst_n(rst_n), .init(ax_init), .adv(vds_adv), .wrap(vds_wrap),
        .cfg_start(vds_start), .cfg_step(vds_step), .cfg_npts(vds_npts),
        .code(vds_code), .idx(res_di), .last(vds_last), .step_clip(vds_clip)
    );

    assign sample_n  = (NEG_ID != 0) ? ADC_W'(sat_neg(int'($signed(adc_data)), ADC_MIN, ADC_MAX))
                                     : adc_data;
    assign dac_load  = (state == LOAD);
    assign adc_req   = (state == CONV);
    assign res_valid = (state == EMIT);
    assign res_last  = (state == EMIT) && vgs_last && vds_last;
    assign res_id    = sample_q;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        state_n  = state;
        ax_init  = 1'b0;
        vgs_adv  = 1'b0;
        vds_adv  = 1'b0;
        vds_wrap = 1'b0;
        if (state != IDLE && abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_n = LOAD;
                    ax_init = 1'b1;
                end
                LOAD:   state_n = (settle_q == '0) ? CONV : SETTLE;
                SETTLE: if (settle_cnt == '0) state_n = CONV;
                CONV:   if (adc_ack) state_n = EMIT;
                EMIT: if (res_ready) begin
                    if (vgs_last && vds_last) begin
                        state_n = DONE;
                    end else begin
                        state_n = LOAD;
                        if (vds_last) begin
                            vds_wrap = 1'b1;
                            vgs_adv  = 1'b1;
                        end else begin
                            vds_adv = 1'b1;
                        end
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_q   <= '0;
            settle_cnt <= '0;
            sample_q   <= '0;
            clip       <= 1'b0;
        end else begin
            state <= state_n;
            if (ax_init) begin
                settle_q <= settle_cycles;
                clip     <= 1'b0;
            end else if ((vgs_adv && vgs_clip) || (vds_adv && vds_clip)) begin
                clip <= 1'b1;
            end
            if (state == LOAD) settle_cnt <= settle_q - 1'b1;
            else if (state == SETTLE) settle_cnt <= settle_cnt - 1'b1;
            if (state == CONV && adc_ack && !abort) sample_q <= sample_n;
        end
    end

endmodule

// File: tb/tb_dc_bias_sweep_sequencer.sv
// tb/tb_dc_bias_sweep_sequencer.sv - directed self-checking bench for dc_bias_sweep_sequencer
module tb_dc_bias_sweep_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [11:0] vgs_start, vds_start;
    logic [12:0] vgs_step, vds_step;
    logic [7:0]  vgs_npts, vds_npts;
    logic [15:0] settle_cycles;
    logic [11:0] vgs_code, vds_code;
    logic        dac_load, adc_req, adc_ack, res_valid, res_ready, res_last, busy, done, clip;
    logic [15:0] adc_data, res_id;
    logic [7:0]  res_gi, res_di;

    dc_bias_sweep_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .vgs_start(vgs_start), .vgs_step(vgs_step), .vgs_npts(vgs_npts),
        .vds_start(vds_start), .vds_step(vds_step), .vds_npts(vds_npts),
        .settle_cycles(settle_cycles), .vgs_code(vgs_code), .vds_code(vds_code),
        .dac_load(dac_load), .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_gi(res_gi),
        .res_di(res_di), .res_last(res_last), .busy(busy), .done(done), .clip(clip)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic        ack_en = 1'b1;
    logic        force_ack = 1'b0;
    int          ack_dly = 2;
    logic [15:0] adc_val = 16'h0000;

    int          nres, nload, nreq, ndone, done_cyc;
    int          r_gi[64], r_di[64], r_vgs[64], r_vds[64], r_last[64], r_cyc[64], r_id[64];
    int          l_vds[64], l_clip[64], l_cyc[64], q_cyc[64];
    logic        req_prev;

    int t1_vgs[6] = '{100, 100, 100, 150, 150, 150};
    int t1_vds[6] = '{0, 1000, 2000, 0, 1000, 2000};
    int t1_gi[6]  = '{0, 0, 0, 1, 1, 1};
    int t1_di[6]  = '{0, 1, 2, 0, 1, 2};
    int t1_last[6] = '{0, 0, 0, 0, 0, 1};
    int t2_vds[3] = '{4000, 4095, 4095};
    int t2_clip[3] = '{0, 1, 1};
    int t4_vgs[4] = '{10, 10, 15, 15};
    int t4_vds[4] = '{500, 300, 500, 300};
    int t4_gi[4]  = '{0, 0, 1, 1};
    int t4_di[4]  = '{0, 1, 0, 1};

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ADC model: acks ack_dly cycles after the request is first seen
    initial begin
        int rcnt;
        rcnt = 0;
        adc_ack = 1'b0;
        adc_data = 16'h0000;
        forever begin
            @(negedge clk);
            adc_ack = 1'b0;
            if (force_ack) begin
                adc_ack = 1'b1;
                adc_data = adc_val;
            end else if (adc_req && ack_en) begin
                rcnt++;
                if (rcnt == ack_dly) begin
                    adc_ack = 1'b1;
                    adc_data = adc_val;
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    initial begin
        nres = 0; nload = 0; nreq = 0; ndone = 0; done_cyc = 0; req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (dac_load && nload < 64) begin
                l_vds[nload] = int'(vds_code);
                l_clip[nload] = int'(clip);
                l_cyc[nload] = cyc;
                nload++;
            end
            if (adc_req && !req_prev && nreq < 64) begin
                q_cyc[nreq] = cyc;
                nreq++;
            end
            req_prev = adc_req;
            if (res_valid && res_ready && nres < 64) begin
                r_gi[nres] = int'(res_gi);
                r_di[nres] = int'(res_di);
                r_vgs[nres] = int'(vgs_code);
                r_vds[nres] = int'(vds_code);
                r_last[nres] = int'(res_last);
                r_id[nres] = int'(res_id);
                r_cyc[nres] = cyc;
                nres++;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_sweep(input int gs, input int gst, input int gn, input int ds,
                               input int dst, input int dn, input int st, input logic ab);
        @(posedge clk);
        #1;
        vgs_start = 12'(gs); vgs_step = 13'(gst); vgs_npts = 8'(gn);
        vds_start = 12'(ds); vds_step = 13'(dst); vds_npts = 8'(dn);
        settle_cycles = 16'(st);
        start = 1'b1;
        abort = ab;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        int b, bl, bq, bd, n;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
        vgs_start = '0; vgs_step = '0; vgs_npts = '0;
        vds_start = '0; vds_step = '0; vds_npts = '0; settle_cycles = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_load", dac_load, 0);
        chk("rst_req", adc_req, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_last", res_last, 0);
        chk("rst_clip", clip, 0);
        chk("rst_vgs", vgs_code, 0);
        chk("rst_gi", res_gi, 0);
        chk("rst_id", res_id, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 2 x 3 sweep, settle 4, ADC sample 0x0010 negates to 0xFFF0
        adc_val = 16'h0010;
        b = nres; bl = nload; bq = nreq; bd = ndone;
        start_sweep(100, 50, 2, 0, 1000, 3, 4, 1'b0);
        wait_idle(2000, "t1_idle");
        chk("t1_count", nres - b, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t1_vgs%0d", i), r_vgs[b+i], t1_vgs[i]);
            chk($sformatf("t1_vds%0d", i), r_vds[b+i], t1_vds[i]);
            chk($sformatf("t1_gi%0d", i), r_gi[b+i], t1_gi[i]);
            chk($sformatf("t1_di%0d", i), r_di[b+i], t1_di[i]);
            chk($sformatf("t1_last%0d", i), r_last[b+i], t1_last[i]);
            chk($sformatf("t1_id%0d", i), r_id[b+i], 32'h0000fff0);
        end
        chk("t1_latency", q_cyc[bq] - l_cyc[bl], 5);
        chk("t1_done_after_last", done_cyc - r_cyc[b+5], 1);
        chk("t1_done_count", ndone - bd, 1);
        chk("t1_clip", clip, 0);

        // drain axis runs into the top code; 0x8000 saturates to 0x7FFF
        adc_val = 16'h8000;
        b = nres; bl = nload;
        start_sweep(0, 0, 1, 4000, 100, 3, 0, 1'b0);
        wait_idle(2000, "t2_idle");
        chk("t2_loads", nload - bl, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_vds%0d", i), l_vds[bl+i], t2_vds[i]);
            chk($sformatf("t2_clip%0d", i), l_clip[bl+i], t2_clip[i]);
        end
        chk("t2_id", r_id[b], 32'h00007fff);
        chk("t2_clip_sticky", clip, 1);

        // sink back-pressure: payload holds, no new DAC load
        adc_val = 16'h1234;
        res_ready = 1'b0;
        b = nres;
        start_sweep(7, 1, 1, 9, 1, 1, 1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 200);
        chk("t3_valid_seen", res_valid, 1);
        bl = nload;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("t3_hold_valid%0d", i), res_valid, 1);
            chk($sformatf("t3_hold_id%0d", i), res_id, 16'hedcc);
            chk($sformatf("t3_hold_vgs%0d", i), vgs_code, 7);
            chk($sformatf("t3_hold_load%0d", i), nload - bl, 0);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_idle(200, "t3_idle");
        chk("t3_count", nres - b, 1);
        chk("t3_last", r_last[b], 1);

        // abort while waiting for the ADC; a late ack must be ignored
        ack_en = 1'b0;
        b = nres; bd = ndone;
        start_sweep(10, 5, 2, 500, -200, 2, 2, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!adc_req && n < 200);
        chk("t4_req_seen", adc_req, 1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_req", adc_req, 0);
        @(posedge clk);
        #1 force_ack = 1'b1;
        @(posedge clk);
        #1 force_ack = 1'b0;
        @(negedge clk);
        chk("t4_late_ack_busy", busy, 0);
        chk("t4_late_ack_valid", res_valid, 0);
        chk("t4_no_result", nres - b, 0);
        chk("t4_no_done", ndone - bd, 0);
        ack_en = 1'b1;
        adc_val = 16'h0001;
        start_sweep(10, 5, 2, 500, -200, 2, 2, 1'b0);
        wait_idle(2000, "t4_idle");
        chk("t4_count", nres - b, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_vgs%0d", i), r_vgs[b+i], t4_vgs[i]);
            chk($sformatf("t4_vds%0d", i), r_vds[b+i], t4_vds[i]);
            chk($sformatf("t4_gi%0d", i), r_gi[b+i], t4_gi[i]);
            chk($sformatf("t4_di%0d", i), r_di[b+i], t4_di[i]);
            chk($sformatf("t4_id%0d", i), r_id[b+i], 32'h0000ffff);
        end
        chk("t4_done_count", ndone - bd, 1);

        // zero point counts, zero settle; start beats a simultaneous abort
        b = nres; bd = ndone;
        start_sweep(55, 3, 0, 66, 3, 0, 0, 1'b1);
        @(negedge clk);
        chk("t5_start_wins", busy, 1);
        wait_idle(200, "t5_idle");
        chk("t5_count", nres - b, 1);
        chk("t5_last", r_last[b], 1);
        chk("t5_gi", r_gi[b], 0);
        chk("t5_di", r_di[b], 0);
        chk("t5_vgs", r_vgs[b], 55);
        chk("t5_vds", r_vds[b], 66);
        chk("t5_done_count", ndone - bd, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
